// File: rtl/led_scan_sequencer_pkg.sv
// Shared types and sizes for the 8-digit 7-segment scan controller.
package led_scan_pkg;
  localparam int WORD_W   = 16;
  localparam int N_DIGITS = 8;
  localparam int SEG_W    = 8;
  localparam int LEVELS   = 4;
  localparam int DIG_W    = $clog2(N_DIGITS);
  localparam int SUB_W    = $clog2(LEVELS);
  localparam int BIT_W    = $clog2(WORD_W);

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SH_LO  = 3'd2,
    SH_HI  = 3'd3,
    LAT_HI = 3'd4,
    LAT_LO = 3'd5
  } scan_state_t;
endpackage

// File: rtl/led_scan_sequencer_tick_gen.sv
// Free-running prescaler: one-clk tick every CLK_DIV system clocks.
module scan_tick_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));
endmodule

// File: rtl/led_scan_sequencer.sv
// Scan controller for the 8-digit 7-segment Pmod: double-buffered segment
// store, 16-bit serial word per digit, brightness by sub-frame masking.
module led_scan_sequencer
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  bright,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  output logic        commit_pend,
  output logic        frame_done,
  output logic        busy,
  output logic        sclk,
  output logic        rclk,
  output logic        _srclr,
  output logic        serial_data,
  output scan_state_t dbg_state
);
  // Host side: wr_en and commit are taken on any clk, in any state, with no
  // backpressure; commit only arms a copy that is applied at the frame end.

  scan_state_t       state;
  seg_t              back  [N_DIGITS];
  seg_t              front [N_DIGITS];
  logic [DIG_W-1:0]  digit;
  logic [SUB_W-1:0]  sub;
  logic [SUB_W-1:0]  bright_q;
  logic [SUB_W-1:0]  bright_now;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] load_word;
  logic [BIT_W-1:0]  bit_idx;
  logic [N_DIGITS-1:0] sel;
  seg_t              seg;
  logic              srclr_q;
  logic              tick;
  logic              frame_end;
  logic              last_digit;
  logic              last_sub;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign last_digit = (digit == DIG_W'(N_DIGITS - 1));
  assign last_sub   = (sub == SUB_W'(LEVELS - 1));
  assign frame_end  = tick && (state == LAT_LO) && last_digit && last_sub;

  // The brightness used for the first word of a frame is the freshly sampled one.
  always_comb begin
    bright_now = bright_q;
    if (digit == '0 && sub == '0) bright_now = bright;
    sel       = N_DIGITS'(1) << digit;
    seg       = (sub < bright_now) ? front[digit] : '0;
    load_word = {sel, seg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      // Swap reads back before this clk's write lands, so front gets the old value.
      if (frame_end && commit_pend) begin
        for (int i = 0; i < N_DIGITS; i++) front[i] <= back[i];
        commit_pend <= 1'b0;
      end
      if (commit) commit_pend <= 1'b1;
      if (wr_en) back[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      digit       <= '0;
      sub         <= '0;
      bright_q    <= '0;
      word        <= '0;
      bit_idx     <= '0;
      sclk        <= 1'b0;
      rclk        <= 1'b0;
      serial_data <= 1'b0;
      frame_done  <= 1'b0;
      srclr_q     <= 1'b0;
    end else begin
      srclr_q    <= 1'b1;
      frame_done <= frame_end;
      if (tick) begin
        case (state)
          IDLE: begin
            if (enable) state <= LOAD;
          end
          LOAD: begin
            if (digit == '0 && sub == '0) bright_q <= bright;
            word    <= load_word;
            bit_idx <= BIT_W'(WORD_W - 1);
            state   <= SH_LO;
          end
          SH_LO: begin
            serial_data <= word[bit_idx];
            sclk        <= 1'b0;
            state       <= SH_HI;
          end
          SH_HI: begin
            sclk <= 1'b1;
            if (bit_idx == '0) begin
              state <= LAT_HI;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
              state   <= SH_LO;
            end
          end
          LAT_HI: begin
            sclk  <= 1'b0;
            rclk  <= 1'b1;
            state <= LAT_LO;
          end
          LAT_LO: begin
            rclk        <= 1'b0;
            serial_data <= 1'b0;
            if (last_digit) begin
              digit <= '0;
              sub   <= last_sub ? '0 : sub + SUB_W'(1);
            end else begin
              digit <= digit + DIG_W'(1);
            end
            state <= enable ? LOAD : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign _srclr    = srclr_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer with CLK_DIV=2 (one word = 70 clks).
module tb_led_scan_sequencer;
  timeunit 1ns;
  timeprecision 1ns;
  import led_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  bright = 2'd0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        commit = 1'b0;
  logic        commit_pend, frame_done, busy, sclk, rclk, srclr, serial_data;
  scan_state_t dbg_state;

  int total = 0;
  int bad = 0;

  // bus-functional monitor of the Pmod pins
  logic [15:0] sh = 16'h0;
  logic [15:0] last_word = 16'h0;
  int          nsclk = 0;
  int          last_nsclk = 0;
  int          sclk_total = 0;
  int          rclk_cnt = 0;
  longint      rclk_last = 0;
  longint      rclk_period = 0;
  longint      fd_last = 0;
  longint      fd_period = 0;

  led_scan_sequencer #(.CLK_DIV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bright      (bright),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_pend (commit_pend),
    .frame_done  (frame_done),
    .busy        (busy),
    .sclk        (sclk),
    .rclk        (rclk),
    ._srclr      (srclr),
    .serial_data (serial_data),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    sh = {sh[14:0], serial_data};
    nsclk++;
    sclk_total++;
  end

  always @(posedge rclk) begin
    last_word   = sh;
    last_nsclk  = nsclk;
    nsclk       = 0;
    rclk_cnt++;
    rclk_period = $time - rclk_last;
    rclk_last   = $time;
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_period = $time - fd_last;
      fd_last   = $time;
    end
  end

  task automatic wait_rclk(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (rclk_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic write_back(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {sclk, rclk, serial_data, frame_done, busy, commit_pend, srclr};
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 7'b0); end
    rst_n = 1'b1;
    #1;
    total++;
    if (srclr !== 1'b0) begin bad++; $display("FAIL srclr_before_edge got=%b want=0", srclr); end
    @(posedge clk); #1;
    total++;
    if (srclr !== 1'b1) begin bad++; $display("FAIL srclr_release got=%b want=1", srclr); end
    repeat (200) @(negedge clk);
    total++;
    if (sclk_total !== 0 || rclk_cnt !== 0) begin
      bad++; $display("FAIL idle_quiet sclk=%0d rclk=%0d want 0/0", sclk_total, rclk_cnt);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    int base;
    logic [15:0] e;
    bright = 2'd3;
    write_back(3'd0, 8'hA5);
    pulse_commit();
    total++;
    if (commit_pend !== 1'b1) begin bad++; $display("FAIL commit_pend_set got=%b want=1", commit_pend); end
    enable = 1'b1;
    base = rclk_cnt;
    for (int i = 0; i < 32; i++) begin
      wait_rclk(base + i + 1, ok);
      e = {8'h01 << (i % 8), 8'h00};
      total++;
      if (!ok || last_word !== e) begin
        bad++; $display("FAIL frame1_word%0d got=%h want=%h ok=%0d", i, last_word, e, ok);
      end
    end
    wait_fd(ok);
    #1;
    total++;
    if (!ok || commit_pend !== 1'b0) begin
      bad++; $display("FAIL swap_clears_pend got=%b want=0 ok=%0d", commit_pend, ok);
    end
    wait_rclk(base + 33, ok);
    total++;
    if (!ok || last_word !== 16'h01A5) begin bad++; $display("FAIL frame2_word0 got=%h want=01a5", last_word); end
    total++;
    if (last_nsclk !== 16) begin bad++; $display("FAIL sclk_per_word got=%0d want=16", last_nsclk); end
    total++;
    if (rclk_period !== 700) begin bad++; $display("FAIL word_period got=%0d want=700", rclk_period); end
    wait_rclk(base + 34, ok);
    total++;
    if (!ok || last_word !== 16'h0200) begin bad++; $display("FAIL frame2_word1 got=%h want=0200", last_word); end
  endtask

  task automatic test_brightness();
    bit ok;
    int base;
    logic [15:0] e;
    bright = 2'd1;
    for (int d = 0; d < 8; d++) write_back(3'(d), 8'hFF);
    pulse_commit();
    wait_fd(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bright_sync_timeout got=0 want=1"); end
    base = rclk_cnt;
    for (int i = 0; i < 32; i++) begin
      wait_rclk(base + i + 1, ok);
      e[15:8] = 8'h01 << (i % 8);
      e[7:0]  = (i < 8) ? 8'hFF : 8'h00;
      total++;
      if (!ok || last_word !== e) begin
        bad++; $display("FAIL bright_word%0d got=%h want=%h ok=%0d", i, last_word, e, ok);
      end
    end
    wait_fd(ok);
    #1;
    total++;
    if (!ok || fd_period !== 22400) begin
      bad++; $display("FAIL frame_period got=%0d want=22400 ok=%0d", fd_period, ok);
    end
  endtask

  task automatic test_swap_collision();
    bit ok;
    int base;
    wait_fd(ok);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    total++;
    if (!ok || commit_pend !== 1'b1) begin bad++; $display("FAIL coll_pend got=%b want=1", commit_pend); end
    repeat (2238) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL coll_alignment got=%b want=1", frame_done); end
    total++;
    if (commit_pend !== 1'b0) begin bad++; $display("FAIL coll_pend_clear got=%b want=0", commit_pend); end
    base = rclk_cnt;
    wait_rclk(base + 3, ok);
    total++;
    if (!ok || last_word !== 16'h04FF) begin bad++; $display("FAIL coll_old_value got=%h want=04ff", last_word); end
    pulse_commit();
    wait_fd(ok);
    base = rclk_cnt;
    wait_rclk(base + 3, ok);
    total++;
    if (!ok || last_word !== 16'h043C) begin bad++; $display("FAIL coll_new_value got=%h want=043c", last_word); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int rc, st;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (nsclk == 8) begin ok = 1'b1; break; end
    end
    rc = rclk_cnt;
    enable = 1'b0;
    wait_rclk(rc + 1, ok);
    total++;
    if (!ok || last_word !== 16'h08FF) begin bad++; $display("FAIL drop_word got=%h want=08ff", last_word); end
    total++;
    if (last_nsclk !== 16) begin bad++; $display("FAIL drop_sclk got=%0d want=16", last_nsclk); end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || dbg_state !== IDLE) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
    st = sclk_total;
    repeat (200) @(negedge clk);
    total++;
    if (rclk_cnt !== rc + 1 || sclk_total !== st || serial_data !== 1'b0) begin
      bad++; $display("FAIL drop_quiet rclk=%0d sclk=%0d want %0d/%0d", rclk_cnt, sclk_total, rc + 1, st);
    end
    enable = 1'b1;
    wait_rclk(rc + 2, ok);
    total++;
    if (!ok || last_word !== 16'h10FF) begin bad++; $display("FAIL resume_digit got=%h want=10ff", last_word); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rc;
    logic [5:0] obs;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sclk === 1'b1 && serial_data === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL mid_sync got=0 want=1"); end
    rc = rclk_cnt;
    #2 rst_n = 1'b0;
    #1;
    obs = {sclk, rclk, serial_data, srclr, busy, commit_pend};
    total++;
    if (obs !== 6'b0) begin bad++; $display("FAIL mid_reset_outputs got=%b want=%b", obs, 6'b0); end
    repeat (10) @(negedge clk);
    total++;
    if (rclk_cnt !== rc) begin bad++; $display("FAIL mid_reset_rclk got=%0d want=%0d", rclk_cnt, rc); end
    rst_n = 1'b1;
    wait_rclk(rc + 1, ok);
    total++;
    if (!ok || last_word !== 16'h0100) begin bad++; $display("FAIL post_reset_word got=%h want=0100", last_word); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_brightness();
    test_swap_collision();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
